ov7670_pattern_gen: RTL and testbench

OV7670_PATTERN_GEN -- requirements
Module: ov7670_pattern_gen

---
 rtl/ov7670_pattern_gen_if.sv | 13 +
 rtl/ov7670_pattern_gen.sv | 109 ++++++++++
 tb/tb_ov7670_pattern_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ov7670_pattern_gen_if.sv
// ov7670_pattern_gen_if: emulated OV7670 parallel video bus
// ov_pclk  : pixel clock (half the generator clock)
// ov_vsync : frame sync, active-high
// ov_href  : line valid, active-high
// ov_d     : RGB565 byte stream, high byte first
interface ov7670_pattern_gen_if;
    logic       ov_pclk;
    logic       ov_vsync;
    logic       ov_href;
    logic [7:0] ov_d;
    modport master (output ov_pclk, ov_vsync, ov_href, ov_d);
    modport slave (input ov_pclk, ov_vsync, ov_href, ov_d);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: OV7670-style RGB565 test-pattern source
// clk25/reset : clock and synchronous active-high reset
// enable      : frame generation request, sampled at frame boundaries
// mode        : 0 colour bars, 1 ramp, 2 solid, 3 checker (latched per frame)
// solid_rgb   : RGB565 colour for mode 2 (latched per frame)
// frame_done  : one-cycle pulse as the last byte period of a frame ends
// ov          : sensor bus (pclk, vsync, href, d)
module ov7670_pattern_gen #(
    parameter int H_PIX       = 320,
    parameter int V_LINES     = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic                        clk25,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [15:0]                 solid_rgb,
    output logic                        frame_done,
    ov7670_pattern_gen_if.master        ov
);
    localparam int H_TOT = 2 * H_PIX + H_BLANK;
    localparam int HW    = $clog2(H_TOT);
    localparam int V_A   = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
    localparam int V_B   = V_LINES > V_FRONT ? V_LINES : V_FRONT;
    localparam int LW    = $clog2((V_A > V_B ? V_A : V_B) + 1);
    localparam int BAR_W = H_PIX >= 8 ? H_PIX / 8 : 1;
    // index 0 is the leftmost bar
    localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                         16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t          state, state_next;
    logic            phase;
    logic [HW-1:0]   hcnt, x, bar_i;
    logic [LW-1:0]   line, last_line;
    logic [7:0]      frame_cnt;
    logic [1:0]      mode_q;
    logic [15:0]     rgb_q, pix;
    logic [2:0]      bar;
    logic            line_end, seg_end, start, href;

    // phase=1 marks the second half of a byte period; all counters and
    // outputs move on the edge that ends it, so pclk falls as data changes
    always_comb begin
        last_line  = state == VSYNC  ? LW'(VSYNC_LINES - 1) :
                     state == VBACK  ? LW'(V_BACK - 1) :
                     state == ACTIVE ? LW'(V_LINES - 1) : LW'(V_FRONT - 1);
        line_end   = hcnt == HW'(H_TOT - 1);
        seg_end    = line_end && line == last_line;
        state_next = !phase          ? state :
                     state == IDLE   ? (enable ? VSYNC : IDLE) :
                     !seg_end        ? state :
                     state == VSYNC  ? VBACK :
                     state == VBACK  ? ACTIVE :
                     state == ACTIVE ? VFRONT : (enable ? VSYNC : IDLE);
        start      = phase && state != VSYNC && state_next == VSYNC;
        frame_done = phase && state == VFRONT && seg_end && !reset;
    end

    always_ff @(posedge clk25)
        if (reset)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge clk25) begin
        if (reset) begin
            phase     <= 1'b0;
            hcnt      <= '0;
            line      <= '0;
            frame_cnt <= '0;
            mode_q    <= '0;
            rgb_q     <= '0;
        end else begin
            phase <= ~phase;
            if (phase && state != IDLE) begin
                hcnt <= line_end ? '0 : hcnt + 1'b1;
                line <= seg_end ? '0 : line_end ? line + 1'b1 : line;
            end
            if (start) begin
                mode_q <= mode;
                rgb_q  <= solid_rgb;
            end
            if (frame_done)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // in ACTIVE the line counter is the active-line index y
    always_comb begin
        x     = hcnt >> 1;
        bar_i = x / HW'(BAR_W);
        bar   = bar_i > HW'(7) ? 3'd7 : bar_i[2:0];
        href  = state == ACTIVE && hcnt < HW'(2 * H_PIX);
        pix   = mode_q == 2'd0 ? BARS[bar] :
                mode_q == 2'd1 ? {5'(x >> 4), 6'(x >> 2), 5'(line >> 3)} :
                mode_q == 2'd2 ? rgb_q :
                (1'(x >> 4) ^ 1'(line >> 4) ^ 1'(frame_cnt)) ? 16'hFFFF : 16'h0000;
    end

    assign ov.ov_pclk  = phase;
    assign ov.ov_vsync = state == VSYNC;
    assign ov.ov_href  = href;
    assign ov.ov_d     = !href ? 8'h00 : hcnt[0] ? pix[7:0] : pix[15:8];
endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// tb_ov7670_pattern_gen: frame-position model plus directed pattern checks
module tb_ov7670_pattern_gen;
    localparam int HP = 64, VL = 34, HB = 4, VS = 2, VB = 2, VF = 2;
    localparam int HT = 2 * HP + HB;
    localparam int FB = HT * (VS + VB + VL + VF);

    logic        clk = 0, reset = 1, enable = 0;
    logic [1:0]  mode = 0;
    logic [15:0] solid_rgb = 0;
    logic        frame_done;

    ov7670_pattern_gen_if ovif();

    ov7670_pattern_gen #(
        .H_PIX(HP), .V_LINES(VL), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk25(clk), .reset(reset), .enable(enable), .mode(mode),
        .solid_rgb(solid_rgb), .frame_done(frame_done), .ov(ovif)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: frame described as a flat byte position since VSYNC entry
    bit          m_phase = 0, in_frame = 0, started = 0;
    int          pos = 0, href_cnt = 0;
    logic [7:0]  m_fcnt = 0;
    logic [1:0]  m_mode = 0;
    logic [15:0] m_rgb = 0;
    logic [7:0]  cap [VL][2*HP];
    int          bars [8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; in_frame = 0; pos = 0; m_fcnt = 0; m_mode = 0; m_rgb = 0; started = 1;
        end else begin
            if (m_phase) begin
                if (!in_frame) begin
                    if (enable) begin in_frame = 1; pos = 0; m_mode = mode; m_rgb = solid_rgb; end
                end else if (pos == FB - 1) begin
                    m_fcnt = m_fcnt + 1;
                    pos = 0;
                    if (enable) begin m_mode = mode; m_rgb = solid_rgb; end
                    else in_frame = 0;
                end else
                    pos++;
            end
            m_phase = ~m_phase;
        end
    end

    always @(negedge clk) if (started) begin
        int ln, h, x, y, pix, d;
        bit vs, hr, fd;
        ln = pos / HT; h = pos % HT;
        vs = in_frame && ln < VS;
        hr = in_frame && ln >= VS + VB && ln < VS + VB + VL && h < 2 * HP;
        y = ln - VS - VB; x = h / 2; pix = 0;
        if (hr)
            case (m_mode)
                2'd0: pix = bars[x / (HP / 8)];
                2'd1: pix = ((x / 16) % 32) * 2048 + ((x / 4) % 64) * 32 + (y / 8) % 32;
                2'd2: pix = int'(m_rgb);
                default: pix = (((x / 16) % 2) ^ ((y / 16) % 2) ^ (m_fcnt % 2)) != 0 ? 'hFFFF : 0;
            endcase
        d = hr ? (h % 2 == 1 ? pix % 256 : pix / 256) : 0;
        fd = m_phase && in_frame && pos == FB - 1 && !reset;
        chk("pclk", 32'(ovif.ov_pclk), 32'(m_phase));
        chk("vsync", 32'(ovif.ov_vsync), 32'(vs));
        chk("href", 32'(ovif.ov_href), 32'(hr));
        chk("d", 32'(ovif.ov_d), 32'(d));
        chk("frame_done", 32'(frame_done), 32'(fd));
        if (hr) cap[y][h] = ovif.ov_d;
        if (reset) href_cnt = 0;
        else if (!ovif.ov_pclk && ovif.ov_href) href_cnt++;
        if (frame_done === 1'b1) begin
            chk("href_bytes", 32'(href_cnt), 32'(2 * HP * VL));
            href_cnt = 0;
        end
    end

    task automatic wait_frame(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 2 * FB + 100);
        chk(name, 32'(frame_done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_line(input string name, input int t);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(in_frame && pos / HT == VS + VB + t) && n < 2 * FB + 100);
        chk(name, 32'(in_frame && pos / HT == VS + VB + t), 32'd1);
    endtask

    initial begin
        int fd_n, vs_n, n;
        repeat (4) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_pclk", 32'(ovif.ov_pclk), 0);
        chk("rst_vsync", 32'(ovif.ov_vsync), 0);
        chk("rst_href", 32'(ovif.ov_href), 0);
        chk("rst_d", 32'(ovif.ov_d), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        repeat (20) @(posedge clk);
        #1 mode = 0; enable = 1;
        repeat (50) @(posedge clk);
        #1 mode = 1;
        wait_frame("frame_bars");
        chk("bar_p0_hi", 32'(cap[0][0]), 'hFF);
        chk("bar_p0_lo", 32'(cap[0][1]), 'hFF);
        chk("bar_p8_hi", 32'(cap[0][16]), 'hFF);
        chk("bar_p8_lo", 32'(cap[0][17]), 'hE0);
        chk("bar_p16_hi", 32'(cap[0][32]), 'h07);
        chk("bar_p16_lo", 32'(cap[0][33]), 'hFF);
        chk("bar_plast_hi", 32'(cap[0][126]), 'h00);
        chk("bar_plast_lo", 32'(cap[0][127]), 'h00);
        mode = 2; solid_rgb = 16'h1234;
        wait_frame("frame_ramp");
        chk("ramp_20_9_hi", 32'(cap[9][40]), 'h08);
        chk("ramp_20_9_lo", 32'(cap[9][41]), 'hA1);
        chk("ramp_63_33_hi", 32'(cap[33][126]), 'h19);
        chk("ramp_63_33_lo", 32'(cap[33][127]), 'hE4);
        wait_line("solid_line5", 5);
        @(posedge clk); #1 solid_rgb = 16'hABCD; mode = 3;
        wait_frame("frame_solid");
        chk("solid_first_hi", 32'(cap[0][0]), 'h12);
        chk("solid_first_lo", 32'(cap[0][1]), 'h34);
        chk("solid_last_hi", 32'(cap[33][126]), 'h12);
        chk("solid_last_lo", 32'(cap[33][127]), 'h34);
        wait_frame("frame_chk_a");
        chk("chkA_0_0", 32'(cap[0][0]), 'hFF);
        chk("chkA_16_0", 32'(cap[0][32]), 'h00);
        chk("chkA_16_16", 32'(cap[16][32]), 'hFF);
        wait_line("chkB_line10", 10);
        @(posedge clk); #1 enable = 0;
        wait_frame("frame_chk_b");
        chk("chkB_0_0", 32'(cap[0][0]), 'h00);
        chk("chkB_0_16", 32'(cap[16][0]), 'hFF);
        fd_n = 0; vs_n = 0;
        repeat (600) begin
            @(negedge clk);
            fd_n += int'(frame_done);
            vs_n += int'(ovif.ov_vsync);
        end
        chk("idle_frame_done", 32'(fd_n), 0);
        chk("idle_vsync", 32'(vs_n), 0);
        @(posedge clk); #1 mode = 0; enable = 1;
        wait_line("abort_line20", 20);
        @(posedge clk); #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_pclk", 32'(ovif.ov_pclk), 0);
        chk("abort_vsync", 32'(ovif.ov_vsync), 0);
        chk("abort_href", 32'(ovif.ov_href), 0);
        chk("abort_d", 32'(ovif.ov_d), 0);
        chk("abort_frame_done", 32'(frame_done), 0);
        @(posedge clk); #1 reset = 0;
        n = 0;
        while (ovif.ov_vsync !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("restart_vsync", 32'(ovif.ov_vsync), 1);
        repeat (3000) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
